// File: rtl/tick_mon_pkg.sv
// Shared types and constants for the tick period monitor.
//   state_e : measurement FSM states (S_WAIT = awaiting first tick, S_MEAS = measuring)
//   MISS_W  : width of the missed-tick (timeout) counter
package tick_mon_pkg;

    typedef enum logic [0:0] {
        S_WAIT = 1'b0,
        S_MEAS = 1'b1
    } state_e;

    localparam int MISS_W = 8;

endpackage

// File: rtl/tick_mon_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk    in  1  clock
//   rst    in  1  synchronous active-high reset
//   clr_i  in  1  synchronous clear (wins over inc_i)
//   inc_i  in  1  increment request; ignored once the count equals MAX
//   cnt_o  out W  current count (registered)
module tick_mon_sat_cnt
    import tick_mon_pkg::*;
#(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: clear first, then increment unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (inc_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tick_period_monitor.sv
// Receive-side checker for single-cycle enable strobes. Measures the number of
// clk cycles between successive strobes, reports each period, flags short,
// long and missing ticks, and asserts in_lock after LOCK_N consecutive
// in-tolerance periods.
// Optional feature: define TICK_MON_MINMAX_EN to track period_min/period_max;
// otherwise both outputs are tied to zero and no min/max registers exist.
// Ports:
//   clk         in  1       clock
//   rst         in  1       synchronous active-high reset
//   tick_in     in  1       strobe under test
//   clr         in  1       synchronous clear of flags, lock, miss_cnt, state
//   period_out  out CNT_W   last measured period in cycles
//   period_vld  out 1       one-cycle pulse when period_out updates
//   in_lock     out 1       LOCK_N consecutive good periods seen
//   err_short   out 1       sticky: a period below EXP_PERIOD-TOL
//   err_long    out 1       sticky: a period above EXP_PERIOD+TOL, or timeout
//   miss_cnt    out 8       saturating timeout count
//   period_min  out CNT_W   smallest period since clr (feature build only)
//   period_max  out CNT_W   largest period since clr (feature build only)
module tick_period_monitor
    import tick_mon_pkg::*;
#(
    parameter int EXP_PERIOD = 100_000_000,
    parameter int TOL        = 16,
    parameter int LOCK_N     = 2,
    parameter int CNT_W      = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    input  logic              clr,
    output logic [CNT_W-1:0]  period_out,
    output logic              period_vld,
    output logic              in_lock,
    output logic              err_short,
    output logic              err_long,
    output logic [MISS_W-1:0] miss_cnt,
    output logic [CNT_W-1:0]  period_min,
    output logic [CNT_W-1:0]  period_max
);

    localparam int RUN_W = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] LONG_LIM  = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] SHORT_LIM = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [RUN_W-1:0] LOCK_PRE  = RUN_W'(LOCK_N - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             vld_q, vld_d;
    logic             lock_q, lock_d;
    logic             es_q, es_d;
    logic             el_q, el_d;

    logic [CNT_W-1:0] period_s;
    logic             tick_meas_s;
    logic             timeout_s;
    logic             short_s;
    logic             long_s;
    logic             good_s;
    logic             run_clr_s;
    logic [RUN_W-1:0] run_cnt_s;

    // event decode; clr suppresses every event in its cycle
    always_comb begin
        period_s    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        tick_meas_s = (state_q == S_MEAS) && tick_in && !clr;
        timeout_s   = (state_q == S_MEAS) && !tick_in && !clr && (cnt_q == LONG_LIM);
        short_s     = tick_meas_s && (period_s < SHORT_LIM);
        long_s      = tick_meas_s && (period_s > LONG_LIM);
        good_s      = tick_meas_s && !short_s && !long_s;
        run_clr_s   = clr || short_s || long_s || timeout_s;
    end

    // FSM, period counter, sticky flags and lock next-state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        vld_d    = 1'b0;
        lock_d   = lock_q;
        es_d     = es_q;
        el_d     = el_q;
        if (clr) begin
            state_d = S_WAIT;
            cnt_d   = {CNT_W{1'b0}};
            lock_d  = 1'b0;
            es_d    = 1'b0;
            el_d    = 1'b0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    cnt_d = {CNT_W{1'b0}};
                    if (tick_in) begin
                        state_d = S_MEAS;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_MEAS: begin
                    if (tick_in) begin
                        // a tick in the timeout cycle still closes a (long) period
                        cnt_d    = {CNT_W{1'b0}};
                        period_d = period_s;
                        vld_d    = 1'b1;
                        if (short_s) begin
                            es_d   = 1'b1;
                            lock_d = 1'b0;
                        end else if (long_s) begin
                            el_d   = 1'b1;
                            lock_d = 1'b0;
                        end else if (run_cnt_s >= LOCK_PRE) begin
                            lock_d = 1'b1;
                        end else begin
                            lock_d = lock_q;
                        end
                    end else if (timeout_s) begin
                        state_d = S_WAIT;
                        cnt_d   = {CNT_W{1'b0}};
                        el_d    = 1'b1;
                        lock_d  = 1'b0;
                    end else begin
                        cnt_d = period_s;
                    end
                end
                default: begin
                    state_d = S_WAIT;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // state registers; clr is folded into the next-state logic
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_WAIT;
            cnt_q    <= {CNT_W{1'b0}};
            period_q <= {CNT_W{1'b0}};
            vld_q    <= 1'b0;
            lock_q   <= 1'b0;
            es_q     <= 1'b0;
            el_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            vld_q    <= vld_d;
            lock_q   <= lock_d;
            es_q     <= es_d;
            el_q     <= el_d;
        end
    end

    tick_mon_sat_cnt #(
        .W   (RUN_W),
        .MAX (LOCK_N)
    ) u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (run_clr_s),
        .inc_i (good_s),
        .cnt_o (run_cnt_s)
    );

    tick_mon_sat_cnt #(
        .W   (MISS_W),
        .MAX ((1 << MISS_W) - 1)
    ) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .inc_i (timeout_s),
        .cnt_o (miss_cnt)
    );

`ifdef TICK_MON_MINMAX_EN
    logic [CNT_W-1:0] min_q;
    logic [CNT_W-1:0] max_q;

    // running extremes, updated alongside period_out
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            min_q <= {CNT_W{1'b1}};
            max_q <= {CNT_W{1'b0}};
        end else if (tick_meas_s) begin
            if (period_s < min_q) begin
                min_q <= period_s;
            end
            if (period_s > max_q) begin
                max_q <= period_s;
            end
        end
    end

    assign period_min = min_q;
    assign period_max = max_q;
`else
    assign period_min = {CNT_W{1'b0}};
    assign period_max = {CNT_W{1'b0}};
`endif

    assign period_out = period_q;
    assign period_vld = vld_q;
    assign in_lock    = lock_q;
    assign err_short  = es_q;
    assign err_long   = el_q;

endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed bench for tick_period_monitor with a time-based reference model
// (tracks the cycle index of the last tick rather than a counter).
module tb_tick_period_monitor;

    localparam int EXP    = 100;
    localparam int TOL    = 4;
    localparam int LOCK_N = 2;
    localparam int CNT_W  = 8;
`ifdef TICK_MON_MINMAX_EN
    localparam bit MINMAX = 1'b1;
`else
    localparam bit MINMAX = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick_in = 1'b0;
    logic             clr = 1'b0;
    logic [CNT_W-1:0] period_out;
    logic             period_vld;
    logic             in_lock;
    logic             err_short;
    logic             err_long;
    logic [7:0]       miss_cnt;
    logic [CNT_W-1:0] period_min;
    logic [CNT_W-1:0] period_max;

    tick_period_monitor #(
        .EXP_PERIOD (EXP),
        .TOL        (TOL),
        .LOCK_N     (LOCK_N),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .clr        (clr),
        .period_out (period_out),
        .period_vld (period_vld),
        .in_lock    (in_lock),
        .err_short  (err_short),
        .err_long   (err_long),
        .miss_cnt   (miss_cnt),
        .period_min (period_min),
        .period_max (period_max)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 50)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit     m_meas = 1'b0;
    longint m_cyc  = 0;
    longint m_last = 0;
    int     m_period = 0, m_vld = 0, m_lock = 0, m_run = 0;
    int     m_es = 0, m_el = 0, m_miss = 0, m_min = 255, m_max = 0;

    task automatic model_step();
        longint elapsed;
        m_cyc++;
        if (rst || clr) begin
            if (rst) m_period = 0;
            m_meas = 1'b0; m_vld = 0; m_lock = 0; m_run = 0;
            m_es = 0; m_el = 0; m_miss = 0; m_min = 255; m_max = 0;
        end else begin
            m_vld = 0;
            if (m_meas) begin
                elapsed = m_cyc - m_last;
                if (tick_in) begin
                    m_period = int'(elapsed);
                    m_vld    = 1;
                    m_last   = m_cyc;
                    if (elapsed < EXP - TOL) begin
                        m_es = 1; m_run = 0;
                    end else if (elapsed > EXP + TOL) begin
                        m_el = 1; m_run = 0;
                    end else if (m_run < LOCK_N) begin
                        m_run++;
                    end
                    m_lock = (m_run >= LOCK_N) ? 1 : 0;
                    if (m_period < m_min) m_min = m_period;
                    if (m_period > m_max) m_max = m_period;
                end else if (elapsed == EXP + TOL + 1) begin
                    m_meas = 1'b0; m_el = 1; m_run = 0; m_lock = 0;
                    if (m_miss < 255) m_miss++;
                end
            end else if (tick_in) begin
                m_meas = 1'b1;
                m_last = m_cyc;
            end
        end
    endtask

    // model advances on each active edge, DUT compared on the opposite edge
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("vld",       32'(period_vld), 32'(m_vld));
            chk("period",    32'(period_out), 32'(m_period));
            chk("lock",      32'(in_lock),    32'(m_lock));
            chk("err_short", 32'(err_short),  32'(m_es));
            chk("err_long",  32'(err_long),   32'(m_el));
            chk("miss",      32'(miss_cnt),   32'(m_miss));
            chk("min",       32'(period_min), MINMAX ? 32'(m_min) : 32'd0);
            chk("max",       32'(period_max), MINMAX ? 32'(m_max) : 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) cycle();
    endtask

    task automatic send_tick();
        tick_in = 1'b1;
        cycle();
        tick_in = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
    endtask

    // close a period of gap g (previous tick already sent) and pin the result
    task automatic gap_check(input int g, input int exp_lock, input int exp_es, input int exp_el);
        wait_n(g - 1);
        send_tick();
        chk("lit_vld",   32'(period_vld), 32'd1);
        chk("lit_per",   32'(period_out), 32'(g));
        chk("lit_lock",  32'(in_lock),    32'(exp_lock));
        chk("lit_short", 32'(err_short),  32'(exp_es));
        chk("lit_long",  32'(err_long),   32'(exp_el));
    endtask

    initial begin
        rst = 1'b1;
        wait_n(3);
        chk("rst_per",  32'(period_out), 32'd0);
        chk("rst_vld",  32'(period_vld), 32'd0);
        chk("rst_lock", 32'(in_lock),    32'd0);
        chk("rst_miss", 32'(miss_cnt),   32'd0);
        chk("rst_min",  32'(period_min), MINMAX ? 32'd255 : 32'd0);
        rst = 1'b0;
        wait_n(5);

        // steady 100-cycle ticks: first tick only starts, lock on 2nd period
        send_tick();
        chk("first_novld", 32'(period_vld), 32'd0);
        gap_check(100, 0, 0, 0);
        gap_check(100, 1, 0, 0);
        gap_check(100, 1, 0, 0);

        // tolerance edges are both good
        gap_check(96, 1, 0, 0);
        gap_check(104, 1, 0, 0);
        // one below the lower bound
        gap_check(95, 0, 1, 0);
        // tick exactly in the timeout cycle: measured long period, no miss
        gap_check(105, 0, 1, 1);
        chk("lit_miss0", 32'(miss_cnt), 32'd0);

        // timeout
        pulse_clr();
        chk("clr_short", 32'(err_short), 32'd0);
        chk("clr_long",  32'(err_long),  32'd0);
        send_tick();
        wait_n(200);
        chk("to_long", 32'(err_long), 32'd1);
        chk("to_miss", 32'(miss_cnt), 32'd1);
        chk("to_lock", 32'(in_lock),  32'd0);
        send_tick();
        chk("restart_novld", 32'(period_vld), 32'd0);
        gap_check(100, 0, 0, 1);
        gap_check(100, 1, 0, 1);

        // clr together with a tick while locked
        wait_n(99);
        tick_in = 1'b1;
        clr     = 1'b1;
        cycle();
        tick_in = 1'b0;
        clr     = 1'b0;
        chk("clrt_vld",  32'(period_vld), 32'd0);
        chk("clrt_lock", 32'(in_lock),    32'd0);
        chk("clrt_long", 32'(err_long),   32'd0);
        chk("clrt_miss", 32'(miss_cnt),   32'd0);
        chk("clrt_per",  32'(period_out), 32'd100);
        // back in S_WAIT: next tick only starts a measurement
        wait_n(99);
        send_tick();
        chk("wait_novld", 32'(period_vld), 32'd0);
        gap_check(100, 0, 0, 0);

        // min/max tracking
        pulse_clr();
        send_tick();
        gap_check(98, 0, 0, 0);
        gap_check(103, 1, 0, 0);
        gap_check(100, 1, 0, 0);
        chk("lit_min", 32'(period_min), MINMAX ? 32'd98  : 32'd0);
        chk("lit_max", 32'(period_max), MINMAX ? 32'd103 : 32'd0);
        pulse_clr();
        chk("clr_min", 32'(period_min), MINMAX ? 32'd255 : 32'd0);
        chk("clr_max", 32'(period_max), 32'd0);
        wait_n(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
